// File: rtl/secuenciador_if.sv
// rtl/secuenciador_if.sv - control sequencer for the vector processor fetch stage
//
// Purpose:
//   Accepts an algorithm request and steers the fetch stage PC to that
//   algorithm's ROM entry point. It flushes the single stale instruction
//   left by the synchronous ROM, then marks fetched instructions valid for
//   decode until a HALT opcode arrives or the watchdog limit is reached.
//
// Parameters:
//   HALT_OP        opcode that terminates an algorithm
//   MAX_INSTR      watchdog limit on valid instructions per run (1..1023)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_start        request pulse, sampled only in IDLE
//   i_algoritmo    algorithm index 0..7 (same encoding as fetch sel_dir)
//   i_opcode       opcode currently presented by the fetch stage
//   o_sel_dir      registered entry-point select to the fetch stage
//   o_sel_pc       1 = load entry point into PC, 0 = PC+1
//   o_instr_valid  current fetch instruction belongs to the running algorithm
//   o_busy         run in progress (SALTO, FLUSH, EJEC)
//   o_done         one-cycle completion pulse (FIN)
//   o_error        run ended by watchdog; held until next accepted start
//   o_instr_count  valid instructions issued in the current/last run

module secuenciador_if #(
   parameter logic [3:0]  HALT_OP   = 4'b1111,
   parameter int unsigned MAX_INSTR = 1023
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [2:0] i_algoritmo,
   input  logic [3:0] i_opcode,
   output logic [2:0] o_sel_dir,
   output logic       o_sel_pc,
   output logic       o_instr_valid,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_error,
   output logic [9:0] o_instr_count
);

   localparam logic [9:0] C_MAX = 10'(MAX_INSTR);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SALTO = 3'd1,
      S_FLUSH = 3'd2,
      S_EJEC  = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_sel_dir;
   logic [9:0] r_count;
   logic       r_error;

   logic       w_halt;
   logic       w_latch;
   logic       w_count_inc;
   logic       w_wdog;

   assign w_halt = (i_opcode == HALT_OP);

   // Next-state and output decode. Every output except o_instr_valid depends
   // on the state register alone; o_instr_valid additionally masks the HALT
   // opcode so it is never forwarded to decode.
   always_comb begin
      w_next        = r_state;
      w_latch       = 1'b0;
      w_count_inc   = 1'b0;
      w_wdog        = 1'b0;
      o_sel_pc      = 1'b0;
      o_instr_valid = 1'b0;
      o_busy        = 1'b0;
      o_done        = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_latch = 1'b1;
               w_next  = S_SALTO;
            end
         end

         S_SALTO: begin
            o_sel_pc = 1'b1;
            o_busy   = 1'b1;
            w_next   = S_FLUSH;
         end

         // ROM output is still the pre-jump instruction this cycle.
         S_FLUSH: begin
            o_busy = 1'b1;
            w_next = S_EJEC;
         end

         S_EJEC: begin
            o_busy = 1'b1;
            if (w_halt) begin
               // HALT takes priority over the watchdog: it is not counted,
               // so it can never be the instruction that hits the limit.
               w_next = S_FIN;
            end else begin
               o_instr_valid = 1'b1;
               if (r_count != C_MAX) begin
                  w_count_inc = 1'b1;
               end
               // Count reaches the limit with this instruction.
               if (r_count >= (C_MAX - 10'd1)) begin
                  w_wdog = 1'b1;
                  w_next = S_FIN;
               end
            end
         end

         S_FIN: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end

         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_sel_dir <= 3'd0;
         r_count   <= 10'd0;
         r_error   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_sel_dir <= i_algoritmo;
            r_count   <= 10'd0;
            r_error   <= 1'b0;
         end
         if (w_count_inc) begin
            r_count <= r_count + 10'd1;
         end
         if (w_wdog) begin
            r_error <= 1'b1;
         end
      end
   end

   assign o_sel_dir     = r_sel_dir;
   assign o_error       = r_error;
   assign o_instr_count = r_count;

endmodule

// File: doc/secuenciador_if.md
# secuenciador_if

Control sequencer that drives the instruction fetch stage of the vector processor: it accepts an algorithm request, steers the fetch stage's PC to that algorithm's ROM entry point via `sel_pc`/`sel_dir`, and flushes the stale fetch cycle. It then marks each fetched instruction valid for decode until a HALT opcode arrives, and reports completion. It sits between the top-level command interface and the fetch stage, and consumes the fetch stage's `opcode` output.

## Interface
- `HALT_OP`, default 4'b1111: opcode that terminates an algorithm.
- `MAX_INSTR`, default 1023: watchdog limit on valid instructions per run, range 1..1023.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `algoritmo`  in  3  algorithm index 0..7; the same encoding as the fetch stage's `sel_dir`.
- `opcode`  in  4  opcode of the instruction currently output by the fetch stage.
- `sel_dir`  out  3  entry-point select to the fetch stage.
- `sel_pc`  out  1  1 = load entry point into PC; 0 = PC+1.
- `instr_valid`  out  1  current fetch-stage instruction is part of the running algorithm.
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  the run ended by watchdog; held until the next accepted start.
- `instr_count`  out  10  number of valid instructions issued in the current or last run.

## Operation
- Fetch-stage behaviour:
  - The PC register loads every cycle.
  - The ROM is synchronous, with a 1-cycle read latency.
  - A jump therefore leaves exactly one stale instruction, which must be flushed.
- FSM states: IDLE, SALTO, FLUSH, EJEC, FIN.
- IDLE: all outputs inactive; the PC free-runs harmlessly.
  - `start`=1 → latch `algoritmo` into the `sel_dir` register, clear `instr_count` and `error`, go to SALTO.
- SALTO: `sel_pc`=1, `busy`=1. Next state is FLUSH unconditionally.
- FLUSH: `sel_pc`=0, `busy`=1, `instr_valid`=0. Next state is EJEC.
- EJEC: `busy`=1.
  - If `opcode`==HALT_OP: `instr_valid`=0, go to FIN; the HALT is not forwarded or counted.
  - Otherwise: `instr_valid`=1 and `instr_count` increments.
  - If the count reaches MAX_INSTR after the increment: set `error`, go to FIN.
- FIN: `done`=1, `busy`=0. Next state is IDLE.
- `sel_dir` is registered and holds the last latched algorithm between runs.
- `sel_pc`, `instr_valid`, `busy` and `done` are decoded from the state register only, with no combinational path from inputs except `opcode` → `instr_valid`.
- `start` is ignored outside IDLE, including in FIN. No queuing.
- Changes on `algoritmo` after start acceptance have no effect.
- `instr_count` saturates at MAX_INSTR and never wraps.
- Reset, asynchronous at any time including mid-run: state=IDLE, `sel_dir`=0, `sel_pc`=0, `instr_valid`=0, `busy`=0, `done`=0, `error`=0, `instr_count`=0.

## Timing
- Start accepted at edge k.
- SALTO during cycle k..k+1: `sel_pc`=1, and the PC loads the entry point at edge k+1.
- FLUSH during cycle k+1..k+2: the ROM output is stale.
- From edge k+2, `opcode` reflects the entry-point instruction and the state is EJEC.
- Start-to-first-`instr_valid` latency: 2 cycles.
- HALT seen in EJEC at cycle n → `done` high in cycle n+1, back in IDLE at n+2.
  - Earliest restart: `start` sampled at edge n+2.
- `busy` is high for exactly the SALTO, FLUSH and EJEC cycles.
- `done` never coincides with `busy` or `instr_valid`.
- HALT on the first EJEC cycle (empty algorithm): `instr_count`=0, `done` 3 cycles after start acceptance.
- HALT and watchdog limit in the same cycle: HALT wins, `error` stays 0.

## Test plan
- Reset asserted mid-EJEC, asynchronously between edges:
  - All outputs go to reset values immediately.
  - After deassert, `start` with `algoritmo`=2 → `sel_dir`=2, `sel_pc`=1 for one cycle.
- `algoritmo`=6, ROM program of 8 non-HALT instructions then HALT:
  - `instr_valid` is high for exactly 8 cycles starting 2 cycles after start.
  - `instr_count`=8.
  - `done` pulses once, `error`=0.
- Entry point contains HALT immediately:
  - `instr_valid` never asserts.
  - `done` comes 3 cycles after start acceptance, `instr_count`=0.
- MAX_INSTR=4, program without HALT:
  - 4 valid cycles, then `done`=1 with `error`=1 and `instr_count`=4.
  - `error` stays 1 in IDLE until the next start clears it.
- `start` held high continuously with `algoritmo` toggling between 3 and 7:
  - Each run uses the value latched in IDLE.
  - No start is accepted in SALTO, FLUSH, EJEC or FIN.
  - Back-to-back runs are separated by FIN and IDLE.
- MAX_INSTR=4, HALT arrives on the 5th EJEC cycle, where the count would reach the limit:
  - Watchdog fires on the 4th instruction first, so `error`=1.
  - Repeat with MAX_INSTR=5: `error`=0, `instr_count`=4.
